// File: rtl/pu_argmax.sv
// Sequential argmax over LANES-wide packed PU output words, accumulated across GROUPS words.
// Optional macro PU_ARGMAX_SIGNED_EN switches the lane compare to two's-complement.
module pu_argmax #(
  parameter int LANES  = 8,
  parameter int WIDTH  = 8,
  parameter int GROUPS = 1,
  parameter int IDXW   = (LANES * GROUPS > 1) ? $clog2(LANES * GROUPS) : 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*WIDTH-1:0]   in_data,
  input  logic                     abort,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IDXW-1:0]          out_index,
  output logic [WIDTH-1:0]         out_max
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int GW = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [LANES*WIDTH-1:0]   word_q, word_d;
  logic [LW-1:0]            lane_q, lane_d;
  logic [GW-1:0]            group_q, group_d;
  logic [WIDTH-1:0]         best_val_q, best_val_d;
  logic [IDXW-1:0]          best_idx_q, best_idx_d;
  logic [IDXW-1:0]          out_index_q, out_index_d;
  logic [WIDTH-1:0]         out_max_q, out_max_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;

  logic [WIDTH-1:0]         lane_val [LANES];
  logic [WIDTH-1:0]         cur_val;
  logic [IDXW-1:0]          cur_idx;
  logic                     first_lane;
  logic                     greater;
  logic                     take_new;
  logic [WIDTH-1:0]         new_val;
  logic [IDXW-1:0]          new_idx;
  logic                     last_lane;
  logic                     last_group;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_val[gi] = word_q[gi*WIDTH +: WIDTH];
    end
  endgenerate

  assign cur_val    = lane_val[lane_q];
  assign cur_idx    = IDXW'(group_q) * IDXW'(LANES) + IDXW'(lane_q);
  assign first_lane = (group_q == '0) && (lane_q == '0);
  assign last_lane  = (lane_q == LW'(LANES - 1));
  assign last_group = (group_q == GW'(GROUPS - 1));

`ifdef PU_ARGMAX_SIGNED_EN
  assign greater = $signed(cur_val) > $signed(best_val_q);
`else
  assign greater = cur_val > best_val_q;
`endif

  // Strict compare keeps the lowest index on ties; the very first lane seeds the best.
  assign take_new = first_lane || greater;
  assign new_val  = take_new ? cur_val : best_val_q;
  assign new_idx  = take_new ? cur_idx : best_idx_q;

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    lane_d      = lane_q;
    group_d     = group_q;
    best_val_d  = best_val_q;
    best_idx_d  = best_idx_q;
    out_index_d = out_index_q;
    out_max_d   = out_max_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    if (abort) begin
      state_d     = ST_IDLE;
      lane_d      = '0;
      group_d     = '0;
      best_val_d  = '0;
      best_idx_d  = '0;
      in_ready_d  = 1'b1;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            word_d     = in_data;
            lane_d     = '0;
            state_d    = ST_SCAN;
            in_ready_d = 1'b0;
          end
        end
        ST_SCAN: begin
          best_val_d = new_val;
          best_idx_d = new_idx;
          if (last_lane) begin
            lane_d = '0;
            if (last_group) begin
              out_index_d = new_idx;
              out_max_d   = new_val;
              group_d     = '0;
              state_d     = ST_DONE;
              out_valid_d = 1'b1;
            end else begin
              group_d    = group_q + GW'(1);
              state_d    = ST_IDLE;
              in_ready_d = 1'b1;
            end
          end else begin
            lane_d = lane_q + LW'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            in_ready_d  = 1'b1;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      word_q      <= '0;
      lane_q      <= '0;
      group_q     <= '0;
      best_val_q  <= '0;
      best_idx_q  <= '0;
      out_index_q <= '0;
      out_max_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      lane_q      <= lane_d;
      group_q     <= group_d;
      best_val_q  <= best_val_d;
      best_idx_q  <= best_idx_d;
      out_index_q <= out_index_d;
      out_max_q   <= out_max_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_index = out_index_q;
  assign out_max   = out_max_q;

endmodule

// File: tb/tb_pu_argmax.sv
// Scoreboard bench for pu_argmax: a GROUPS=1 instance and a GROUPS=2 instance on one clock.
module tb_pu_argmax;

  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] mx;
  } res_t;

  logic        clk;
  logic        rstn;

  logic        in_valid1, in_ready1, abort1, out_valid1, out_ready1;
  logic [63:0] in_data1;
  logic [2:0]  out_index1;
  logic [7:0]  out_max1;

  logic        in_valid2, in_ready2, abort2, out_valid2, out_ready2;
  logic [63:0] in_data2;
  logic [3:0]  out_index2;
  logic [7:0]  out_max2;

  int checks = 0;
  int errors = 0;

  res_t exp_q[$];
  logic [11:0] exp2_q[$];
  res_t last_exp;

  pu_argmax #(.LANES(8), .WIDTH(8), .GROUPS(1)) dut1 (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .abort(abort1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_index(out_index1), .out_max(out_max1)
  );

  pu_argmax #(.LANES(8), .WIDTH(8), .GROUPS(2)) dut2 (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
    .abort(abort2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .out_index(out_index2), .out_max(out_max2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic res_t model(input logic [63:0] w);
    res_t r;
    logic [7:0] v;
    bit gt;
    r.idx = 3'd0;
    r.mx  = w[7:0];
    for (int k = 1; k < 8; k++) begin
      v = w[k*8 +: 8];
`ifdef PU_ARGMAX_SIGNED_EN
      gt = $signed(v) > $signed(r.mx);
`else
      gt = v > r.mx;
`endif
      if (gt) begin
        r.idx = 3'(k);
        r.mx  = v;
      end
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word to dut1, wait for acceptance, then count cycles until out_valid.
  task automatic run_vec1(input logic [63:0] w, output int lat);
    int waitc;
    in_data1  = w;
    in_valid1 = 1'b1;
    exp_q.push_back(model(w));
    waitc = 0;
    while (!in_ready1 && waitc < 40) begin
      tick();
      waitc++;
    end
    tick();
    in_valid1 = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    tick();
    tick();
    checks++;
    if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || out_index1 !== 3'd0 || out_max1 !== 8'd0) begin
      errors++;
      $display("FAIL reset1: rdy=%b vld=%b idx=%0d max=%0d, want rdy=1 vld=0 idx=0 max=0",
               in_ready1, out_valid1, out_index1, out_max1);
    end
    checks++;
    if (in_ready2 !== 1'b1 || out_valid2 !== 1'b0 || out_index2 !== 4'd0 || out_max2 !== 8'd0) begin
      errors++;
      $display("FAIL reset2: rdy=%b vld=%b idx=%0d max=%0d, want rdy=1 vld=0 idx=0 max=0",
               in_ready2, out_valid2, out_index2, out_max2);
    end
    rstn = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int lat;
    res_t e;
    run_vec1(64'h05_00_01_09_07_02_09_03, lat);
    checks++;
    if (lat !== 8) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles, want 8", lat);
    end
    e = exp_q.pop_front();
    last_exp = e;
    checks++;
    if (out_index1 !== 3'd1 || out_max1 !== 8'd9 || {out_index1, out_max1} !== e) begin
      errors++;
      $display("FAIL basic_result: idx=%0d max=%0d, want idx=1 max=9", out_index1, out_max1);
    end
    $display("basic: idx=%0d max=%0d latency=%0d", out_index1, out_max1, lat);
    tick();
  endtask

  task automatic test_backpressure();
    int lat;
    res_t e;
    logic stable_ok;
    out_ready1 = 1'b0;
    run_vec1(64'h10_20_30_E0_50_60_70_80, lat);
    e = exp_q.pop_front();
    last_exp = e;
    checks++;
    if (out_valid1 !== 1'b1 || {out_index1, out_max1} !== e) begin
      errors++;
      $display("FAIL bp_result: vld=%b idx=%0d max=%0d, want vld=1 idx=%0d max=%0d",
               out_valid1, out_index1, out_max1, e.idx, e.mx);
    end
    stable_ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (out_valid1 !== 1'b1 || in_ready1 !== 1'b0 || {out_index1, out_max1} !== e) stable_ok = 1'b0;
    end
    checks++;
    if (!stable_ok) begin
      errors++;
      $display("FAIL bp_hold: vld=%b rdy=%b idx=%0d max=%0d, want vld=1 rdy=0 idx=%0d max=%0d",
               out_valid1, in_ready1, out_index1, out_max1, e.idx, e.mx);
    end
    out_ready1 = 1'b1;
    tick();
    checks++;
    if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || {out_index1, out_max1} !== e) begin
      errors++;
      $display("FAIL bp_release: rdy=%b vld=%b idx=%0d max=%0d, want rdy=1 vld=0 held result",
               in_ready1, out_valid1, out_index1, out_max1);
    end
    $display("backpressure: idx=%0d max=%0d", out_index1, out_max1);
  endtask

  task automatic test_boundaries();
    logic [63:0] vecs [5];
    int lat;
    res_t e;
    vecs[0] = 64'h33_33_33_33_33_33_33_33;
    vecs[1] = 64'hFF_00_00_00_00_00_00_00;
    vecs[2] = 64'hFE_FE_FE_FE_FE_FE_FE_FF;
    vecs[3] = 64'hA0_90_FF_81_F0_FE_80_F0;
    vecs[4] = 64'h00_00_00_00_00_00_80_7F;
    for (int i = 0; i < 5; i++) begin
      run_vec1(vecs[i], lat);
      e = exp_q.pop_front();
      last_exp = e;
      checks++;
      if (lat !== 8 || {out_index1, out_max1} !== e) begin
        errors++;
        $display("FAIL boundary%0d: lat=%0d idx=%0d max=%h, want lat=8 idx=%0d max=%h",
                 i, lat, out_index1, out_max1, e.idx, e.mx);
      end
      if (i == 3) begin
        checks++;
        if (out_index1 !== 3'd5 || out_max1 !== 8'hFF) begin
          errors++;
          $display("FAIL mixed_vec: idx=%0d max=%h, want idx=5 max=ff", out_index1, out_max1);
        end
      end
      if (i == 4) begin
        checks++;
`ifdef PU_ARGMAX_SIGNED_EN
        if (out_index1 !== 3'd0 || out_max1 !== 8'h7F) begin
          errors++;
          $display("FAIL sign_vec: idx=%0d max=%h, want idx=0 max=7f", out_index1, out_max1);
        end
`else
        if (out_index1 !== 3'd1 || out_max1 !== 8'h80) begin
          errors++;
          $display("FAIL sign_vec: idx=%0d max=%h, want idx=1 max=80", out_index1, out_max1);
        end
`endif
      end
      $display("boundary%0d: idx=%0d max=%h", i, out_index1, out_max1);
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    res_t e;
    logic [63:0] w;
    for (int i = 0; i < 6; i++) begin
      w = {$urandom, $urandom};
      run_vec1(w, lat);
      e = exp_q.pop_front();
      last_exp = e;
      checks++;
      if (lat !== 8 || {out_index1, out_max1} !== e) begin
        errors++;
        $display("FAIL b2b%0d: lat=%0d idx=%0d max=%h, want lat=8 idx=%0d max=%h",
                 i, lat, out_index1, out_max1, e.idx, e.mx);
      end
      tick();
      checks++;
      if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
        errors++;
        $display("FAIL b2b_ready%0d: rdy=%b vld=%b, want rdy=1 vld=0", i, in_ready1, out_valid1);
      end
      $display("b2b%0d: word=%h idx=%0d max=%h", i, w, e.idx, e.mx);
    end
  endtask

  task automatic test_groups();
    int cnt;
    logic [11:0] e2;
    exp2_q.push_back({4'd14, 8'd12});
    in_data2  = 64'h04_04_04_04_04_04_04_04;
    in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    in_data2  = 64'hFF_FF_FF_FF_FF_FF_FF_FF;
    cnt = 0;
    while (!in_ready2 && cnt < 40) begin
      tick();
      cnt++;
    end
    checks++;
    if (cnt !== 8 || out_valid2 !== 1'b0) begin
      errors++;
      $display("FAIL grp_rearm: cycles=%0d vld=%b, want cycles=8 vld=0", cnt, out_valid2);
    end
    in_data2  = 64'h00_0C_00_00_00_00_00_00;
    in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    cnt = 0;
    while (!out_valid2 && cnt < 40) begin
      tick();
      cnt++;
    end
    e2 = exp2_q.pop_front();
    checks++;
    if (cnt !== 8 || {out_index2, out_max2} !== e2) begin
      errors++;
      $display("FAIL grp_result: lat=%0d idx=%0d max=%0d, want lat=8 idx=14 max=12",
               cnt, out_index2, out_max2);
    end
    $display("groups: idx=%0d max=%0d", out_index2, out_max2);
    tick();
  endtask

  task automatic test_abort();
    int lat;
    int seen;
    res_t e;
    in_data1  = 64'h50_50_50_50_50_50_50_50;
    in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    tick();
    tick();
    tick();
    abort1    = 1'b1;
    in_valid1 = 1'b1;
    in_data1  = 64'hFF_FF_FF_FF_FF_FF_FF_FF;
    tick();
    abort1    = 1'b0;
    in_valid1 = 1'b0;
    checks++;
    if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || {out_index1, out_max1} !== last_exp) begin
      errors++;
      $display("FAIL abort_state: rdy=%b vld=%b idx=%0d max=%h, want rdy=1 vld=0 idx=%0d max=%h",
               in_ready1, out_valid1, out_index1, out_max1, last_exp.idx, last_exp.mx);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid1 === 1'b1 || in_ready1 !== 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_quiet: %0d bad cycles, want 0", seen);
    end
    run_vec1(64'h01_00_00_00_00_00_00_00, lat);
    e = exp_q.pop_front();
    last_exp = e;
    checks++;
    if (lat !== 8 || out_index1 !== 3'd7 || out_max1 !== 8'd1 || {out_index1, out_max1} !== e) begin
      errors++;
      $display("FAIL abort_next: lat=%0d idx=%0d max=%0d, want lat=8 idx=7 max=1",
               lat, out_index1, out_max1);
    end
    $display("abort: next idx=%0d max=%0d", out_index1, out_max1);
    tick();
  endtask

  task automatic test_async_reset();
    int lat;
    res_t e;
    in_data1  = 64'h05_00_01_09_07_02_09_03;
    in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    tick();
    tick();
    tick();
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (in_ready1 !== 1'b1 || out_valid1 !== 1'b0 || out_index1 !== 3'd0 || out_max1 !== 8'd0) begin
      errors++;
      $display("FAIL async_reset: rdy=%b vld=%b idx=%0d max=%0d, want rdy=1 vld=0 idx=0 max=0",
               in_ready1, out_valid1, out_index1, out_max1);
    end
    tick();
    tick();
    rstn = 1'b1;
    tick();
    run_vec1(64'h05_00_01_09_07_02_09_03, lat);
    e = exp_q.pop_front();
    checks++;
    if (lat !== 8 || out_index1 !== 3'd1 || out_max1 !== 8'd9 || {out_index1, out_max1} !== e) begin
      errors++;
      $display("FAIL async_rerun: lat=%0d idx=%0d max=%0d, want lat=8 idx=1 max=9",
               lat, out_index1, out_max1);
    end
    $display("async_reset: rerun idx=%0d max=%0d", out_index1, out_max1);
    tick();
  endtask

  initial begin
    rstn       = 1'b0;
    in_valid1  = 1'b0;
    in_data1   = '0;
    abort1     = 1'b0;
    out_ready1 = 1'b1;
    in_valid2  = 1'b0;
    in_data2   = '0;
    abort2     = 1'b0;
    out_ready2 = 1'b1;
    last_exp   = '0;
    #3;
    test_reset();
    test_basic();
    test_backpressure();
    test_boundaries();
    test_back_to_back();
    test_groups();
    test_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
